// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-PC, resolves branch conditions against
// datapath status and drives control bits while a microprogram runs.
module micro_sequencer #(
    parameter int AW         = 5,
    parameter int DW         = 23,
    parameter int CW         = 15,
    parameter int DEPTH      = 18,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       status,
    output logic [AW-1:0]    rom_addr,
    input  logic [DW-1:0]    rom_data,
    output logic [CW-1:0]    ctrl,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    localparam logic [AW-1:0] START = AW'(START_ADDR);
    localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);

    state_t         state;
    logic [AW-1:0]  upc;
    logic [2:0]     cond;
    logic [AW-1:0]  target;
    logic [AW:0]    inc;
    logic [AW:0]    nxt;
    logic           taken;
    logic           halt;
    logic           illegal;

    // One extra bit on the next address so upc+1 wrapping past the top is caught by the range check.
    always_comb begin
        cond   = rom_data[CW+AW+2 -: 3];
        target = rom_data[CW+AW-1 -: AW];
        inc    = {1'b0, upc} + (AW+1)'(1);
        case (cond)
            3'd0:    taken = 1'b0;
            3'd1:    taken = status[0];
            3'd2:    taken = status[1];
            3'd3:    taken = status[2];
            3'd4:    taken = 1'b1;
            3'd5:    taken = !status[0];
            3'd6:    taken = !status[1];
            default: taken = !status[2];
        endcase
        nxt     = taken ? {1'b0, target} : inc;
        halt    = (cond == 3'd4) && (target == upc);
        illegal = (nxt >= LIMIT);
    end

    always_comb begin
        ctrl = '0;
        if (state == RUN)
            ctrl = rom_data[CW-1:0];
    end

    assign rom_addr = upc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            upc    <= START;
            cycles <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state  <= RUN;
                        upc    <= START;
                        cycles <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycles != '1)
                        cycles <= cycles + CNT_W'(1);
                    if (halt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (illegal) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        upc <= nxt[AW-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
